// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types, bit positions and defaults for the keypad IO port
package io_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam int VALID_BIT        = 15;
  localparam int OVR_BIT          = 14;
  localparam int DEF_SCAN_DIV     = 15000;
  localparam int DEF_DEBOUNCE_CNT = 4;

  // Index of the lowest-numbered zero bit; lower rows/columns win ties.
  function automatic logic [1:0] low_index(input logic [3:0] bits);
    low_index = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!bits[i]) low_index = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_reader_if.sv
// rtl/keypad_reader_if.sv - CPU-side IO read port of the keypad reader
interface keypad_reader_if;
  logic        io_read_signal;
  logic [15:0] io_read_data;
  logic        key_valid;

  modport master (output io_read_signal, input io_read_data, input key_valid);
  modport slave  (input io_read_signal, output io_read_data, output key_valid);
endinterface

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - free-running scan tick, one cycle high every SCAN_DIV+1 clocks
module keypad_tick_gen
  import io_pkg::*;
#(
  parameter int SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int W = (SCAN_DIV < 1) ? 1 : $clog2(SCAN_DIV + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == W'(SCAN_DIV)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == W'(SCAN_DIV));

endmodule

// File: rtl/keypad_reader.sv
// rtl/keypad_reader.sv - 4x4 matrix keypad scanner with debounce and CPU read port
module keypad_reader
  import io_pkg::*;
#(
  parameter int SCAN_DIV     = DEF_SCAN_DIV,
  parameter int DEBOUNCE_CNT = DEF_DEBOUNCE_CNT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      row_in,
  output logic [3:0]      col_out,
  keypad_reader_if.slave  io
);

  localparam int DW = $clog2(DEBOUNCE_CNT + 1);

  logic          tick;
  logic [3:0]    sync1;
  logic [3:0]    rows_s;
  kp_state_t     state;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [DW-1:0] deb_cnt;
  logic [3:0]    key_code;
  logic          key_valid_r;
  logic          overrun;

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 4'hF;
      rows_s <= 4'hF;
    end else begin
      sync1  <= row_in;
      rows_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SCAN;
      col_out     <= 4'b1110;
      row_idx     <= 2'd0;
      col_idx     <= 2'd0;
      deb_cnt     <= '0;
      key_code    <= 4'd0;
      key_valid_r <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (io.io_read_signal) begin
        key_valid_r <= 1'b0;
        overrun     <= 1'b0;
      end
      if (tick) begin
        case (state)
          SCAN: begin
            if (rows_s == 4'hF) begin
              col_out <= {col_out[2:0], col_out[3]};
            end else begin
              row_idx <= low_index(rows_s);
              col_idx <= low_index(col_out);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!rows_s[row_idx]) begin
              deb_cnt <= deb_cnt + 1'b1;
              if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) begin
                // A read in the same edge already consumed the old key.
                key_code    <= {row_idx, col_idx};
                key_valid_r <= 1'b1;
                overrun     <= key_valid_r & ~io.io_read_signal;
                state       <= HOLD;
              end
            end else begin
              col_out <= {col_out[2:0], col_out[3]};
              state   <= SCAN;
            end
          end
          HOLD: begin
            if (rows_s == 4'hF) begin
              deb_cnt <= '0;
              state   <= RELEASE;
            end
          end
          RELEASE: begin
            if (rows_s == 4'hF) begin
              deb_cnt <= deb_cnt + 1'b1;
              if (deb_cnt == DW'(DEBOUNCE_CNT - 1)) state <= SCAN;
            end else begin
              state <= HOLD;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    io.io_read_data            = '0;
    io.io_read_data[VALID_BIT] = key_valid_r;
    io.io_read_data[OVR_BIT]   = overrun;
    io.io_read_data[3:0]       = key_code;
  end

  assign io.key_valid = key_valid_r;

endmodule
